// File: rtl/systolic_array_4x4_pkg.sv
// rtl/systolic_array_4x4_pkg.sv - shared sizes and result-bus field indexing for the 4x4 systolic array
package systolic_array_4x4_pkg;

  localparam int N      = 4;
  localparam int DATA_W = 4;
  localparam int ACC_W  = 10;
  localparam int OUT_W  = N * N * ACC_W;

  // Low bit of PE(i,j)'s accumulator within the flat result bus.
  function automatic int field_lo(input int i, input int j);
    return (N * i + j) * ACC_W;
  endfunction

endpackage

// File: rtl/systolic_array_4x4_pe.sv
// rtl/systolic_array_4x4_pe.sv - one processing element: multiply-accumulate in place, forward operands right/down
module systolic_pe
  import systolic_array_4x4_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = a_in * b_in;

  // Reset branch never looks at a_in/b_in, so undriven operands cannot leak into state.
  always_ff @(posedge clk) begin
    if (!res) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      acc   <= acc + ACC_W'(prod);
      a_out <= a_in;
      b_out <= b_in;
    end
  end

endmodule

// File: rtl/systolic_array_4x4.sv
// rtl/systolic_array_4x4.sv - 4x4 output-stationary systolic array, C = A x B on unsigned 4-bit elements
module systolic_array_4x4
  import systolic_array_4x4_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] a3,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] b2,
  input  logic [DATA_W-1:0] b3,
  output logic [OUT_W-1:0]  out
);

  logic [DATA_W-1:0] a_row [N];
  logic [DATA_W-1:0] b_col [N];

  // a_h[i][j] is the a operand seen by PE(i,j); column N is the right-edge spill.
  logic [DATA_W-1:0] a_h [N][N+1];
  logic [DATA_W-1:0] b_v [N+1][N];
  logic [ACC_W-1:0]  acc [N][N];

  assign a_row[0] = a0;
  assign a_row[1] = a1;
  assign a_row[2] = a2;
  assign a_row[3] = a3;
  assign b_col[0] = b0;
  assign b_col[1] = b1;
  assign b_col[2] = b2;
  assign b_col[3] = b3;

  for (genvar e = 0; e < N; e++) begin : g_edge
    assign a_h[e][0] = a_row[e];
    assign b_v[0][e] = b_col[e];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe u_pe (
        .clk   (clk),
        .res   (res),
        .a_in  (a_h[gi][gj]),
        .b_in  (b_v[gi][gj]),
        .a_out (a_h[gi][gj+1]),
        .b_out (b_v[gi+1][gj]),
        .acc   (acc[gi][gj])
      );

      assign out[field_lo(gi, gj) +: ACC_W] = acc[gi][gj];
    end
  end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// tb/tb_systolic_array_4x4.sv - scoreboard bench for systolic_array_4x4 with skewed directed matrices
module tb_systolic_array_4x4;
  import systolic_array_4x4_pkg::*;

  typedef struct {
    string              name;
    logic [OUT_W-1:0]   exp;
  } sb_item_t;

  logic              clk;
  logic              res;
  logic [DATA_W-1:0] a_in [N];
  logic [DATA_W-1:0] b_in [N];
  logic [OUT_W-1:0]  out;

  logic [DATA_W-1:0] ma [N][N];
  logic [DATA_W-1:0] mb [N][N];

  sb_item_t sb_q[$];
  logic     chk_req;
  int       n_cmp;
  int       n_bad;

  systolic_array_4x4 dut (
    .clk (clk),
    .res (res),
    .a0  (a_in[0]),
    .a1  (a_in[1]),
    .a2  (a_in[2]),
    .a3  (a_in[3]),
    .b0  (b_in[0]),
    .b1  (b_in[1]),
    .b2  (b_in[2]),
    .b3  (b_in[3]),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples on the falling edge, away from where state changes.
  always @(negedge clk) begin
    if (chk_req) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: check requested, scoreboard has 0 entries, required >=1");
      end else begin
        sb_item_t it;
        it = sb_q.pop_front();
        for (int f = 0; f < N * N; f++) begin
          n_cmp++;
          if (out[f*ACC_W +: ACC_W] !== it.exp[f*ACC_W +: ACC_W]) begin
            n_bad++;
            $display("FAIL %s field %0d: got %0d, expected %0d", it.name, f,
                     out[f*ACC_W +: ACC_W], it.exp[f*ACC_W +: ACC_W]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic set_zero();
    for (int k = 0; k < N; k++) begin
      a_in[k] = '0;
      b_in[k] = '0;
    end
  endtask

  task automatic expect_vec(input string name, input logic [OUT_W-1:0] exp);
    sb_item_t it;
    it.name = name;
    it.exp  = exp;
    sb_q.push_back(it);
    chk_req = 1'b1;
  endtask

  function automatic logic [OUT_W-1:0] fill(input int v);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int f = 0; f < N * N; f++) r[f*ACC_W +: ACC_W] = ACC_W'(v);
    return r;
  endfunction

  task automatic load_const(input int va, input int vb);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = DATA_W'(va);
        mb[i][k] = DATA_W'(vb);
      end
  endtask

  // Skewed feed over 10 cycles; reset_at >= 0 drops res for that cycle and checks out==0 after it.
  task automatic feed(input int reset_at);
    for (int t = 0; t < 10; t++) begin
      for (int r = 0; r < N; r++) begin
        a_in[r] = (t - r >= 0 && t - r < N) ? ma[r][t-r] : '0;
        b_in[r] = (t - r >= 0 && t - r < N) ? mb[t-r][r] : '0;
      end
      res = (t == reset_at) ? 1'b0 : 1'b1;
      step();
      if (t == reset_at) begin
        expect_vec("midop_reset_zero", '0);
        res = 1'b1;
      end
    end
    set_zero();
    res = 1'b1;
  endtask

  task automatic do_reset();
    res = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < N; k++) begin
        a_in[k] = DATA_W'($urandom_range(1, 15));
        b_in[k] = DATA_W'($urandom_range(1, 15));
      end
      step();
    end
    set_zero();
    res = 1'b1;
  endtask

  initial begin
    logic [OUT_W-1:0] e;
    n_cmp   = 0;
    n_bad   = 0;
    chk_req = 1'b0;
    res     = 1'b0;
    set_zero();

    do_reset();
    expect_vec("reset_state", '0);
    step();
    for (int c = 0; c < 3; c++) step();
    expect_vec("reset_fwd_cleared", '0);
    step();

    load_const(2, 2);
    feed(-1);
    expect_vec("all2", fill(16));
    step();
    step();
    step();
    expect_vec("all2_hold", fill(16));
    step();

    do_reset();
    a_in[0] = 4'd3;
    b_in[0] = 4'd5;
    step();
    set_zero();
    e = '0;
    e[0 +: ACC_W] = 10'd15;
    expect_vec("pulse_1edge", e);
    step();
    for (int c = 0; c < 9; c++) step();
    expect_vec("pulse_settled", e);
    step();

    // A[i][k] = i+k+1, B = 2*I, so C[i][j] = 2*(i+j+1).
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = DATA_W'(i + k + 1);
        mb[i][k] = (i == k) ? 4'd2 : 4'd0;
      end
    feed(-1);
    e = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) e[field_lo(i, j) +: ACC_W] = ACC_W'(2 * (i + j + 1));
    expect_vec("mixed_2a", e);
    step();

    do_reset();
    load_const(15, 15);
    feed(-1);
    expect_vec("all15", fill(900));
    step();
    feed(-1);
    expect_vec("all15_b2b_wrap", fill(776));
    step();

    // Reset during cycle 4 of an all-2 feed: only operands from cycles >=5 survive.
    // PE(i,j) keeps terms k with k+min(i,j) >= 5: min=3 -> 2 terms (8), min=2 -> 1 term (4), else 0.
    do_reset();
    load_const(2, 2);
    feed(4);
    e = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        e[field_lo(i, j) +: ACC_W] = ((i < j ? i : j) == 3) ? 10'd8 :
                                     ((i < j ? i : j) == 2) ? 10'd4 : 10'd0;
    expect_vec("midop_post_reset", e);
    step();

    step();
    step();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/systolic_array_4x4.md
Name: systolic_array_4x4

Overview:
- 4x4 output-stationary systolic array computing C = A x B for 4x4 matrices of unsigned 4-bit elements.
- Row operands enter on the left edge (a0..a3); column operands enter on the top edge (b0..b3).
- Each processing element (PE) multiply-accumulates in place and forwards its operands right and down.
- All 16 accumulators are exposed on one flat bus for the downstream matrix-result consumer.

Parameters:
- DATA_W, 4: width of each a/b operand (unsigned).
- ACC_W, 10: per-PE accumulator width; 4 x 15 x 15 = 900 fits without overflow.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- res  input  1  synchronous active-low reset.
- a0..a3  input  DATA_W each  row operands, one per row; a_i feeds row i.
- b0..b3  input  DATA_W each  column operands, one per column; b_j feeds column j.
- out  output  16*ACC_W (160)  all accumulators; PE(i,j) at out[(4*i+j)*ACC_W +: ACC_W].

Behaviour:
- One clock; reset is synchronous and active-low.
  - res=0 at a rising edge clears all accumulators and all forwarding registers to 0.
  - out reads 0 from that edge onward.
- Reset has priority over accumulation and applies mid-operation with no exceptions.
- a/b inputs are don't-care while res=0; X on inputs must not reach state during reset.
- PE(i,j) operand selection:
  - a operand: a_i if j==0, else PE(i,j-1)'s registered a.
  - b operand: b_j if i==0, else PE(i-1,j)'s registered b.
- On each rising edge with res=1, every PE does all of the following:
  - acc <= acc + a_op*b_op, where the product is an unsigned 2*DATA_W-bit value zero-extended to ACC_W.
  - a_reg <= a_op.
  - b_reg <= b_op.
- Forwarding latency: operand presented at row i / column j reaches PE(i,j) after j cycles (a) or i cycles (b).
- The caller skews inputs: element A[i][k] goes on a_i and B[k][j] goes on b_j in cycle k+i (respectively k+j), counting from the first cycle after reset release; zeros elsewhere.
- With this skew, PE(i,j) completes after the edge of cycle i+j+3.
  - Full result is valid after 10 edges; out holds steady while inputs stay zero.
- out is driven directly from the accumulator registers: no combinational path from inputs, one-edge visibility.
- Overflow wraps modulo 2^ACC_W with no saturation or flag.
- Accumulators are never cleared except by reset. Back-to-back matrices without reset sum into existing values.
- No valid/ready handshake; the array accumulates every cycle.

Decomposition:
- Shared package: constants N=4, DATA_W=4, ACC_W=10, and the out field-index function (4*i+j)*ACC_W.
- One sub-module, systolic_pe:
  - Inputs: clk, res, a_in, b_in.
  - Outputs: a_out, b_out (registered), acc.
  - Top level is a 4x4 generate of systolic_pe plus output packing.

Test Plan:
- Reset: res=0 for 2 edges with random a/b -> all 16 fields of out = 0; a_reg/b_reg cleared.
- Skewed all-2 matrices (row i starts at cycle i, column j at cycle j, four 2s each, zeros elsewhere) -> after 10 edges every field = 16.
- Single pulse a0=3, b0=5 for one cycle, then zeros -> field PE(0,0)=15, all others 0 permanently.
- Skewed all-15 matrices -> every field = 900 (no overflow).
- Two back-to-back all-15 skewed matrices without reset -> every field = 1800 mod 1024 = 776.
- Reset mid-operation: res=0 at edge 4 of the all-2 run, then continue the feed -> out = 0 right after that edge; later values reflect only post-reset operands.
